// File: rtl/fixed_p_std_div_seq.sv
// Sequential unsigned fixed-point divider: restoring division, one quotient bit per cycle,
// MSB first, over WIDTH+FRACT_WIDTH iterations; results register on entry to DONE.
`timescale 1ns/1ps
module fixed_p_std_div_seq #(
    parameter int WIDTH       = 32,
    parameter int INT_WIDTH   = 8,
    parameter int FRACT_WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             done
);

    localparam int N     = WIDTH + FRACT_WIDTH;
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if ((INT_WIDTH + FRACT_WIDTH != WIDTH) || (FRACT_WIDTH < 1)) begin : g_bad_params
        $error("fixed_p_std_div_seq: need INT_WIDTH+FRACT_WIDTH == WIDTH and FRACT_WIDTH >= 1");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load;
    logic               w_last;
    logic [CNT_W-1:0]   r_cnt;

    logic [N-1:0]       r_dvd;
    logic [WIDTH-1:0]   r_right;
    logic [WIDTH:0]     r_rem;
    logic [N-1:0]       r_quo;

    logic [WIDTH:0]     w_rem_shift;
    logic               w_ge;
    logic [WIDTH:0]     w_rem_next;
    logic [N-1:0]       w_quo_next;
    logic               w_dz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_last      = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (go) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_cnt == LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                       r_cnt <= '0;
        else if (w_load)                  r_cnt <= '0;
        else if (r_state == RUN && !w_last) r_cnt <= r_cnt + 1'b1;
    end

    // One restoring step: shift in the next dividend bit, subtract divisor if it fits.
    assign w_rem_shift = (r_rem << 1) | {{WIDTH{1'b0}}, r_dvd[N-1]};
    assign w_ge        = (w_rem_shift >= {1'b0, r_right});
    assign w_rem_next  = w_ge ? (w_rem_shift - {1'b0, r_right}) : w_rem_shift;
    assign w_quo_next  = (r_quo << 1) | {{(N-1){1'b0}}, w_ge};
    assign w_dz        = (r_right == '0);

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_dvd   <= {left, {FRACT_WIDTH{1'b0}}};
            r_right <= right;
            r_rem   <= '0;
            r_quo   <= '0;
        end else if (r_state == RUN) begin
            r_dvd   <= r_dvd << 1;
            r_rem   <= w_rem_next;
            r_quo   <= w_quo_next;
        end
    end

    // Results latch only on the final iteration; a zero divisor saturates the quotient.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_quotient  <= '0;
            out_remainder <= '0;
            overflow      <= 1'b0;
            div_by_zero   <= 1'b0;
        end else if (w_last) begin
            if (w_dz) begin
                out_quotient  <= '1;
                out_remainder <= '0;
                overflow      <= 1'b0;
                div_by_zero   <= 1'b1;
            end else begin
                out_quotient  <= w_quo_next[WIDTH-1:0];
                out_remainder <= w_rem_next[WIDTH-1:0];
                overflow      <= |w_quo_next[N-1:WIDTH];
                div_by_zero   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fixed_p_std_div_seq.sv
// Scoreboard bench for fixed_p_std_div_seq at WIDTH=8, INT_WIDTH=4, FRACT_WIDTH=4 (N=12).
`timescale 1ns/1ps
module tb_fixed_p_std_div_seq;

    localparam int W  = 8;
    localparam int IW = 4;
    localparam int FW = 4;
    localparam int N  = W + FW;

    logic         clk;
    logic         reset;
    logic         go;
    logic [W-1:0] left;
    logic [W-1:0] right;
    logic [W-1:0] oq;
    logic [W-1:0] orem;
    logic         ov;
    logic         dz;
    logic         done;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         ov;
        logic         dz;
        int           cyc;
        string        name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    fixed_p_std_div_seq #(.WIDTH(W), .INT_WIDTH(IW), .FRACT_WIDTH(FW)) dut (
        .clk           (clk),
        .reset         (reset),
        .go            (go),
        .left          (left),
        .right         (right),
        .out_quotient  (oq),
        .out_remainder (orem),
        .overflow      (ov),
        .div_by_zero   (dz),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_quot"}, 32'(oq),   32'(mon_e.q));
                chk({mon_e.name, "_rem"},  32'(orem), 32'(mon_e.r));
                chk({mon_e.name, "_ovf"},  32'(ov),   32'(mon_e.ov));
                chk({mon_e.name, "_dbz"},  32'(dz),   32'(mon_e.dz));
                chk({mon_e.name, "_cycle"}, 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] q, input logic [W-1:0] r, input logic o,
                        input logic z, input int c, input string name);
        sb.push_back('{q, r, o, z, c, name});
    endtask

    // Called #1 after a posedge with the DUT idle; the current cycle is the go cycle.
    task automatic issue(input logic [W-1:0] l, input logic [W-1:0] r, input logic [W-1:0] q,
                         input logic [W-1:0] rm, input logic o, input logic z, input string name);
        left  = l;
        right = r;
        go    = 1'b1;
        push(q, rm, o, z, cyc + N + 1, name);
        step(1);
        go    = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: pending results %0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_quot"}, 32'(oq),   32'd0);
        chk({tag, "_rem"},  32'(orem), 32'd0);
        chk({tag, "_ovf"},  32'(ov),   32'd0);
        chk({tag, "_dbz"},  32'(dz),   32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    int k;

    initial begin
        reset = 1'b0;
        go    = 1'b0;
        left  = '0;
        right = '0;
        step(2);
        chk_reset_outputs("por");
        reset = 1'b1;
        step(1);

        issue(8'h30, 8'h20, 8'h18, 8'h00, 1'b0, 1'b0, "3_div_2");     wait_idle();
        issue(8'h01, 8'h30, 8'h00, 8'h10, 1'b0, 1'b0, "tiny_div_3");  wait_idle();
        issue(8'hF0, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, "ovf_F0_1");    wait_idle();
        issue(8'h55, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, "div_zero");    wait_idle();
        issue(8'h00, 8'h37, 8'h00, 8'h00, 1'b0, 1'b0, "zero_dvd");    wait_idle();
        issue(8'h10, 8'h30, 8'h05, 8'h10, 1'b0, 1'b0, "1_div_3");     wait_idle();
        issue(8'hFF, 8'hFF, 8'h10, 8'h00, 1'b0, 1'b0, "ff_div_ff");   wait_idle();
        issue(8'h80, 8'h03, 8'hAA, 8'h02, 1'b1, 1'b0, "8_div_3");     wait_idle();
        issue(8'h07, 8'h02, 8'h38, 8'h00, 1'b0, 1'b0, "7_div_2");     wait_idle();

        // Back-to-back with go held high; inputs change while running.
        k     = cyc;
        left  = 8'h30;
        right = 8'h20;
        go    = 1'b1;
        push(8'h18, 8'h00, 1'b0, 1'b0, k + N + 1, "b2b_first");
        step(3);
        left  = 8'hAA;
        right = 8'h07;
        step(2);
        left  = 8'h10;
        right = 8'h30;
        push(8'h05, 8'h10, 1'b0, 1'b0, k + 2 * (N + 2) - 1, "b2b_second");
        step(10);
        go    = 1'b0;
        step(2);
        left  = 8'hFF;
        right = 8'h01;
        wait_idle();

        // Abort with reset in cycle 5 of an operation; no done may follow.
        left  = 8'h30;
        right = 8'h20;
        go    = 1'b1;
        step(1);
        go    = 1'b0;
        step(4);
        #3;
        reset = 1'b0;
        #1;
        chk_reset_outputs("abort");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step(20);

        issue(8'h07, 8'h02, 8'h38, 8'h00, 1'b0, 1'b0, "after_reset"); wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fixed_p_std_div_seq.md
FIXED_P_STD_DIV_SEQ -- requirements
Module: fixed_p_std_div_seq

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the total operand and result width in bits.
REQ-002 Parameter INT_WIDTH, default 8, SHALL set the integer-part width.
REQ-003 Parameter FRACT_WIDTH, default 24, SHALL set the fraction-part width.
REQ-004 Elaboration SHALL fail with $error if INT_WIDTH+FRACT_WIDTH != WIDTH or FRACT_WIDTH < 1.
REQ-005 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-006 Port clk, input, 1 bit, SHALL be the clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1 bit, SHALL be the asynchronous active-low reset (0 = reset asserted).
REQ-008 Port go, input, 1 bit, SHALL request a division; sampled only in IDLE.
REQ-009 Port left, input, WIDTH bits, SHALL be the unsigned fixed-point dividend.
REQ-010 Port right, input, WIDTH bits, SHALL be the unsigned fixed-point divisor.
REQ-011 Port out_quotient, output, WIDTH bits, SHALL be the fixed-point quotient, same format as the inputs.
REQ-012 Port out_remainder, output, WIDTH bits, SHALL be the raw integer remainder of the scaled division.
REQ-013 Port overflow, output, 1 bit, SHALL flag quotient bits lost above WIDTH.
REQ-014 Port div_by_zero, output, 1 bit, SHALL flag right == 0 for the completed operation.
REQ-015 Port done, output, 1 bit, SHALL pulse high for exactly one cycle when results become valid.

Function
REQ-016 Arithmetic SHALL be unsigned: full quotient Q = ({left, FRACT_WIDTH zeros}) / right, N = WIDTH+FRACT_WIDTH bits; R = same dividend mod right.
REQ-017 out_quotient SHALL equal Q[WIDTH-1:0] (truncation, no rounding); overflow SHALL be 1 iff Q[N-1:WIDTH] != 0.
REQ-018 Implementation SHALL be restoring division, one quotient bit per cycle, MSB first, N iterations, partial remainder WIDTH+1 bits.
REQ-019 FSM states SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-020 IDLE: go=1 at an edge SHALL capture left/right into internal registers, clear the iteration counter, go to RUN; go=0 stays IDLE.
REQ-021 RUN: each edge SHALL perform one iteration; after the N-th iteration SHALL go to DONE.
REQ-022 DONE: done=1 combinationally from state; next edge SHALL return to IDLE.
REQ-023 Latency: with the go-sampling cycle as cycle 0, done SHALL be high in cycle N+1 only; fixed, data-independent.
REQ-024 left, right and go SHALL be ignored in RUN and DONE; input changes mid-operation SHALL not affect the result.
REQ-025 go still high in the IDLE cycle after DONE SHALL start a new operation (back-to-back throughput one result per N+2 cycles).
REQ-026 right == 0: latency SHALL be unchanged; out_quotient SHALL be all ones, out_remainder 0, overflow 0, div_by_zero 1.
REQ-027 out_quotient, out_remainder, overflow and div_by_zero SHALL update only on the edge entering DONE and hold until the next entry to DONE.
REQ-028 left == 0 with right != 0 SHALL yield quotient 0, remainder 0, both flags 0.

Reset
REQ-029 reset=0 SHALL immediately, independent of clk, force IDLE, done=0, out_quotient=0, out_remainder=0, overflow=0, div_by_zero=0, counter=0.
REQ-030 Reset asserted during RUN or DONE SHALL abort the operation; no done pulse SHALL follow for it.
REQ-031 After reset deasserts, the first go sampled in IDLE SHALL start a clean operation.

Verification (WIDTH=8, INT_WIDTH=4, FRACT_WIDTH=4, N=12)
REQ-032 left=0x30 (3.0), right=0x20 (2.0), go cycle 0 -> done only in cycle 13, out_quotient=0x18 (1.5), out_remainder=0x00, flags 0.
REQ-033 left=0x01, right=0x30 -> out_quotient=0x00, out_remainder=0x10, overflow=0, div_by_zero=0.
REQ-034 left=0xF0, right=0x01 -> Q=0xF00, out_quotient=0x00, overflow=1, div_by_zero=0.
REQ-035 left=0x55, right=0x00 -> done in cycle 13, out_quotient=0xFF, out_remainder=0x00, div_by_zero=1.
REQ-036 go held high across two ops, inputs changed mid-RUN -> two done pulses 14 cycles apart, each result from inputs captured at its start.
REQ-037 reset pulsed low in cycle 5 of an operation -> outputs 0 at once, no done pulse; a new go after release gives a correct result at the normal latency.
